soc_spram_arb: RTL and testbench
================================

Name: soc_spram_arb

Overview:
Two-master arbiter and sequencer that sits directly upstream of the SoC SPRAM macro wrapper. It drives that wrapper's addr/wdata/wmsk/we port.
- CPU master: single-outstanding, cyc/ack style.
- DMA master (USB audio buffer engine): pipelined req/gnt, may issue every cycle.
DMA has priority, bounded by an anti-starvation counter so the CPU always progresses. Read data from the SPRAM (1-cycle registered latency) is steered back to the master that issued the read.

Parameters:
AW, 14, SPRAM word address width (32-bit words)
STARVE_MAX, 4, max consecutive DMA grants while CPU is waiting before the CPU is forced; range 1..15

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
cpu_addr  input  AW  CPU word address
cpu_wdata  input  32  CPU write data
cpu_wmsk  input  4  CPU byte-write mask, 1 = write byte
cpu_we  input  1  1 = write, 0 = read
cpu_cyc  input  1  CPU request, held until cpu_ack
cpu_ack  output  1  one-cycle completion pulse
cpu_rdata  output  32  CPU read data, valid when cpu_ack=1 for a read
dma_addr  input  AW  DMA word address
dma_wdata  input  32  DMA write data (always full word)
dma_we  input  1  1 = write
dma_req  input  1  DMA request
dma_gnt  output  1  combinational accept; transfer occurs when dma_req & dma_gnt
dma_rvalid  output  1  DMA read data valid
dma_rdata  output  32  DMA read data
spram_addr  output  AW  to SPRAM addr
spram_wdata  output  32  to SPRAM wdata
spram_wmsk  output  4  to SPRAM wmsk
spram_we  output  1  to SPRAM we
spram_rdata  input  32  from SPRAM rdata, 1-cycle latency

Behaviour:
- Clock/reset: one clock, clk; reset rst_n is asynchronous, active-low.
- Reset values: cpu_ack=0, dma_rvalid=0, state=S_IDLE, starve counter=0.
- While rst_n=0: dma_gnt=0 and spram_we=0, forced combinationally.
- States:
  - S_IDLE: CPU is grantable.
  - S_CPU_ACK: the cycle after a CPU grant. cpu_ack=1; CPU is not grantable; DMA is grantable.
- Transitions: S_IDLE -> S_CPU_ACK on CPU grant. S_CPU_ACK -> S_IDLE unconditionally. The CPU must drop cpu_cyc or present a new request in the ack cycle; a request seen during S_CPU_ACK is treated as a new transaction evaluated in S_IDLE.
- cpu_pend = cpu_cyc & (state==S_IDLE).
- Grant, evaluated combinationally each cycle:
  - force_cpu = cpu_pend & (starve == STARVE_MAX).
  - dma_gnt = dma_req & ~force_cpu.
  - cpu_grant = cpu_pend & ~dma_gnt.
- Starve counter:
  - Increments (saturating at STARVE_MAX) when cpu_pend & dma_gnt.
  - Clears on cpu_grant, or when cpu_pend=0.
- SPRAM port mux:
  - DMA granted: addr/wdata from DMA, wmsk=4'hF, we=dma_we.
  - CPU granted: CPU fields, we=cpu_we.
  - No grant: addr=cpu_addr, wdata=cpu_wdata, wmsk=cpu_wmsk, we=0.
- Latency:
  - CPU read and write both ack exactly 1 cycle after grant. cpu_rdata = spram_rdata passthrough, meaningful only on a read ack.
  - DMA read: dma_rvalid=1 exactly 1 cycle after a granted read. dma_rdata = spram_rdata.
  - DMA write: no response.
- Throughput: DMA may be granted every cycle, including the CPU ack cycle. Max CPU rate is one access per 2 cycles.
- Simultaneous CPU and DMA request: DMA wins unless force_cpu.
- Reset mid-operation: a pending ack or rvalid is cleared immediately and never emitted; in-flight data is discarded.

Test Plan:
- Reset: rst_n=0 with cpu_cyc=1 and dma_req=1 -> spram_we=0, dma_gnt=0, cpu_ack=0. After release, first grant goes to DMA.
- CPU write then read: write addr 0x0010, data 0xDEADBEEF, wmsk=4'b0011 -> spram_we=1 with wmsk 4'b0011; ack at +1. Read addr 0x0010 -> ack at +1, cpu_rdata[15:0]=0xBEEF.
- DMA streaming: dma_req=1 for 8 cycles writing addr 0x100..0x107, then 8 reads -> dma_gnt=1 every cycle, dma_rvalid in 8 consecutive cycles, data matching in order.
- Starvation (STARVE_MAX=4): dma_req held high, cpu_cyc asserted -> exactly 4 DMA grants, then dma_gnt=0 for one cycle with CPU granted. DMA is granted in the CPU ack cycle; cpu_ack lands 1 cycle after the CPU grant.
- Collision: CPU read addr 0x20 and DMA read addr 0x30 in the same cycle -> DMA served first; rvalid carries mem[0x30], cpu_ack carries mem[0x20]; no cross-delivery.
- Mid-op reset: assert rst_n low in the cycle between a CPU read grant and its ack -> no cpu_ack pulse, state S_IDLE after release.

Source files
------------

// File: rtl/soc_spram_arb.sv
// soc_spram_arb: two-master (CPU cyc/ack, DMA req/gnt) arbiter in front of the
// SPRAM wrapper. DMA has priority, with a starvation counter that forces a CPU
// grant after STARVE_MAX consecutive DMA wins. Read data is steered back to
// whichever master issued the read one cycle earlier.
module soc_spram_arb #(
    parameter int unsigned AW         = 14,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    // CPU master
    input  logic [AW-1:0] cpu_addr,
    input  logic [31:0]   cpu_wdata,
    input  logic [3:0]    cpu_wmsk,
    input  logic          cpu_we,
    input  logic          cpu_cyc,
    output logic          cpu_ack,
    output logic [31:0]   cpu_rdata,
    // DMA master
    input  logic [AW-1:0] dma_addr,
    input  logic [31:0]   dma_wdata,
    input  logic          dma_we,
    input  logic          dma_req,
    output logic          dma_gnt,
    output logic          dma_rvalid,
    output logic [31:0]   dma_rdata,
    // SPRAM wrapper port
    output logic [AW-1:0] spram_addr,
    output logic [31:0]   spram_wdata,
    output logic [3:0]    spram_wmsk,
    output logic          spram_we,
    input  logic [31:0]   spram_rdata
);

    localparam int unsigned SW = 4;

    typedef enum logic [0:0] {
        S_IDLE    = 1'b0,
        S_CPU_ACK = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [SW-1:0]   starve_q, starve_d;
    logic            cpu_pend;
    logic            force_cpu;
    logic            dma_gnt_c;
    logic            cpu_grant;
    logic            cpu_ack_q;
    logic            dma_rvalid_q;

    // State, starvation counter and response flags; reset kills pending responses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            starve_q     <= '0;
            cpu_ack_q    <= 1'b0;
            dma_rvalid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            starve_q     <= starve_d;
            cpu_ack_q    <= cpu_grant;
            dma_rvalid_q <= dma_gnt_c & ~dma_we;
        end
    end

    // Arbitration, next state and starvation counter update
    always_comb begin
        state_d   = state_q;
        starve_d  = starve_q;
        cpu_pend  = cpu_cyc & (state_q == S_IDLE);
        force_cpu = cpu_pend & (starve_q == SW'(STARVE_MAX));
        // rst_n gating keeps the macro idle while reset is held
        dma_gnt_c = dma_req & ~force_cpu & rst_n;
        cpu_grant = cpu_pend & ~dma_gnt_c & rst_n;

        case (state_q)
            S_IDLE:    if (cpu_grant) state_d = S_CPU_ACK;
            S_CPU_ACK: state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase

        if (!cpu_pend || cpu_grant) begin
            starve_d = '0;
        end else if (dma_gnt_c && (starve_q != SW'(STARVE_MAX))) begin
            starve_d = starve_q + SW'(1);
        end
    end

    // SPRAM port mux; with no grant the CPU fields are presented with we=0
    always_comb begin
        spram_addr  = cpu_addr;
        spram_wdata = cpu_wdata;
        spram_wmsk  = cpu_wmsk;
        spram_we    = 1'b0;
        if (dma_gnt_c) begin
            spram_addr  = dma_addr;
            spram_wdata = dma_wdata;
            spram_wmsk  = 4'hF;
            spram_we    = dma_we;
        end else if (cpu_grant) begin
            spram_we    = cpu_we;
        end
    end

    // Response outputs; read data is a passthrough of the registered macro output
    assign dma_gnt    = dma_gnt_c;
    assign cpu_ack    = cpu_ack_q;
    assign dma_rvalid = dma_rvalid_q;
    assign cpu_rdata  = spram_rdata;
    assign dma_rdata  = spram_rdata;

endmodule

// File: tb/tb_soc_spram_arb.sv
// Directed bench for soc_spram_arb with a behavioural byte-masked SPRAM model.
module tb_soc_spram_arb;

    localparam int unsigned AW = 14;

    logic          clk;
    logic          rst_n;
    logic [AW-1:0] cpu_addr;
    logic [31:0]   cpu_wdata;
    logic [3:0]    cpu_wmsk;
    logic          cpu_we;
    logic          cpu_cyc;
    logic          cpu_ack;
    logic [31:0]   cpu_rdata;
    logic [AW-1:0] dma_addr;
    logic [31:0]   dma_wdata;
    logic          dma_we;
    logic          dma_req;
    logic          dma_gnt;
    logic          dma_rvalid;
    logic [31:0]   dma_rdata;
    logic [AW-1:0] spram_addr;
    logic [31:0]   spram_wdata;
    logic [3:0]    spram_wmsk;
    logic          spram_we;
    logic [31:0]   spram_rdata;

    logic [31:0]   mem [0:(1<<AW)-1];

    int n_cmp = 0;
    int n_err = 0;

    soc_spram_arb #(.AW(AW), .STARVE_MAX(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_wmsk(cpu_wmsk),
        .cpu_we(cpu_we), .cpu_cyc(cpu_cyc), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .dma_addr(dma_addr), .dma_wdata(dma_wdata), .dma_we(dma_we),
        .dma_req(dma_req), .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
        .spram_addr(spram_addr), .spram_wdata(spram_wdata), .spram_wmsk(spram_wmsk),
        .spram_we(spram_we), .spram_rdata(spram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SPRAM model: registered read of the old word, byte-masked write
    always @(posedge clk) begin
        spram_rdata <= mem[spram_addr];
        if (spram_we) begin
            for (int b = 0; b < 4; b++)
                if (spram_wmsk[b]) mem[spram_addr][8*b +: 8] = spram_wdata[8*b +: 8];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = 32'hA5A5_0000 | 32'(i);
        rst_n = 1'b0;
        cpu_cyc = 1'b1; cpu_we = 1'b1; cpu_addr = 14'h3F0; cpu_wdata = 32'h1111_1111; cpu_wmsk = 4'hF;
        dma_req = 1'b1; dma_we = 1'b1; dma_addr = 14'h3F1; dma_wdata = 32'h2222_2222;

        // Reset held with both masters requesting
        cyc(); cyc(); #1;
        check("rst_spram_we", 32'(spram_we), 32'd0);
        check("rst_dma_gnt",  32'(dma_gnt),  32'd0);
        check("rst_cpu_ack",  32'(cpu_ack),  32'd0);
        check("rst_rvalid",   32'(dma_rvalid), 32'd0);

        // Release: DMA takes the first grant
        cyc(); rst_n = 1'b1; #1;
        check("rel_dma_gnt",  32'(dma_gnt),  32'd1);
        check("rel_spram_addr", 32'(spram_addr), 32'h3F1);
        check("rel_wmsk", 32'(spram_wmsk), 32'hF);
        cyc(); cpu_cyc = 1'b0; dma_req = 1'b0; #1;
        check("idle_we", 32'(spram_we), 32'd0);

        // CPU masked write
        cyc(); cpu_cyc = 1'b1; cpu_we = 1'b1; cpu_addr = 14'h010;
        cpu_wdata = 32'hDEAD_BEEF; cpu_wmsk = 4'b0011; #1;
        check("cw_we",   32'(spram_we),   32'd1);
        check("cw_wmsk", 32'(spram_wmsk), 32'h3);
        check("cw_addr", 32'(spram_addr), 32'h010);
        check("cw_ack0", 32'(cpu_ack),    32'd0);
        cyc();
        check("cw_ack1", 32'(cpu_ack), 32'd1);
        cpu_cyc = 1'b0; #1;
        // CPU read back
        cyc(); cpu_cyc = 1'b1; cpu_we = 1'b0; #1;
        check("cr_we", 32'(spram_we), 32'd0);
        check("cr_ack0", 32'(cpu_ack), 32'd0);
        cyc();
        check("cr_ack1", 32'(cpu_ack), 32'd1);
        check("cr_rdata_lo", {16'h0, cpu_rdata[15:0]}, 32'h0000_BEEF);
        check("cr_rdata", cpu_rdata, 32'hA5A5_BEEF);
        cpu_cyc = 1'b0;

        // DMA streaming: 8 writes then 8 reads, one per cycle
        for (int i = 0; i < 8; i++) begin
            cyc(); dma_req = 1'b1; dma_we = 1'b1; dma_addr = 14'h100 + 14'(i);
            dma_wdata = 32'hC0DE_0000 + 32'(i); #1;
            check("dw_gnt", 32'(dma_gnt), 32'd1);
        end
        for (int i = 0; i < 8; i++) begin
            cyc();
            if (i == 0) begin
                check("dr_rvalid0", 32'(dma_rvalid), 32'd0);
            end else begin
                check("dr_rvalid", 32'(dma_rvalid), 32'd1);
                check("dr_rdata", dma_rdata, 32'hC0DE_0000 + 32'(i - 1));
            end
            dma_we = 1'b0; dma_addr = 14'h100 + 14'(i); #1;
            check("dr_gnt", 32'(dma_gnt), 32'd1);
        end
        cyc();
        check("dr_rvalid_last", 32'(dma_rvalid), 32'd1);
        check("dr_rdata_last", dma_rdata, 32'hC0DE_0007);
        dma_req = 1'b0; #1;
        cyc();
        check("dr_rvalid_end", 32'(dma_rvalid), 32'd0);

        // Starvation: four DMA grants, then a forced CPU grant
        dma_req = 1'b1; dma_we = 1'b1; dma_addr = 14'h200; dma_wdata = 32'h5555_5555;
        cpu_cyc = 1'b1; cpu_we = 1'b0; cpu_addr = 14'h010; #1;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) begin cyc(); #1; end
            check("st_dma_gnt", 32'(dma_gnt), 32'd1);
            check("st_ack0", 32'(cpu_ack), 32'd0);
        end
        cyc(); #1;
        check("st_forced_gnt", 32'(dma_gnt), 32'd0);
        check("st_forced_addr", 32'(spram_addr), 32'h010);
        check("st_forced_we", 32'(spram_we), 32'd0);
        cyc();
        check("st_cpu_ack", 32'(cpu_ack), 32'd1);
        check("st_cpu_rdata", cpu_rdata, 32'hA5A5_BEEF);
        cpu_cyc = 1'b0; #1;
        check("st_ackcyc_dma_gnt", 32'(dma_gnt), 32'd1);
        cyc();
        check("st_ack_single", 32'(cpu_ack), 32'd0);
        dma_req = 1'b0;

        // Collision: both read in the same cycle, DMA first
        cpu_cyc = 1'b1; cpu_we = 1'b0; cpu_addr = 14'h020;
        dma_req = 1'b1; dma_we = 1'b0; dma_addr = 14'h030; #1;
        check("co_dma_gnt", 32'(dma_gnt), 32'd1);
        check("co_addr_dma", 32'(spram_addr), 32'h030);
        cyc();
        check("co_rvalid", 32'(dma_rvalid), 32'd1);
        check("co_dma_rdata", dma_rdata, 32'hA5A5_0030);
        check("co_ack0", 32'(cpu_ack), 32'd0);
        dma_req = 1'b0; #1;
        check("co_cpu_addr", 32'(spram_addr), 32'h020);
        cyc();
        check("co_cpu_ack", 32'(cpu_ack), 32'd1);
        check("co_cpu_rdata", cpu_rdata, 32'hA5A5_0020);
        check("co_rvalid_off", 32'(dma_rvalid), 32'd0);
        cpu_cyc = 1'b0;

        // Mid-op reset between CPU read grant and its ack
        cyc(); cpu_cyc = 1'b1; cpu_we = 1'b0; cpu_addr = 14'h020; #1;
        check("mr_grant_addr", 32'(spram_addr), 32'h020);
        #2; rst_n = 1'b0; cpu_cyc = 1'b0; #1;
        check("mr_ack_in_rst", 32'(cpu_ack), 32'd0);
        cyc();
        check("mr_ack_edge", 32'(cpu_ack), 32'd0);
        rst_n = 1'b1;
        cyc();
        check("mr_ack_after", 32'(cpu_ack), 32'd0);
        // Immediate CPU grant proves the FSM came back in S_IDLE
        cpu_cyc = 1'b1; cpu_we = 1'b1; cpu_addr = 14'h040; cpu_wdata = 32'h0BAD_F00D; cpu_wmsk = 4'hF; #1;
        check("mr_idle_we", 32'(spram_we), 32'd1);
        cyc();
        check("mr_idle_ack", 32'(cpu_ack), 32'd1);
        cpu_cyc = 1'b0;
        cyc();
        check("mr_mem_write", mem[14'h040], 32'h0BAD_F00D);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
